// File: rtl/vect_lsu_if.sv
// Request/response and vector-memory signal bundle for the vector load/store unit.
// master = requester plus memory side, slave = the LSU itself.
interface vect_lsu_if #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int AW     = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [AW-1:0]           req_addr;
    logic [LANES*LANE_W-1:0] req_wdata;
    logic [LANES-1:0]        req_mask;
    logic                    rsp_valid;
    logic [LANES*LANE_W-1:0] rsp_rdata;
    logic                    mem_we;
    logic [AW-1:0]           mem_a;
    logic [LANES*LANE_W-1:0] mem_wd;
    logic [LANES*LANE_W-1:0] mem_rd;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_mask, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, mem_we, mem_a, mem_wd
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_mask, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/vect_lsu.sv
// Vector load/store unit: one request at a time, splits lane-unaligned accesses
// into two line accesses and does read-modify-write for partial or unaligned stores.
//
// state | meaning
// IDLE  | ready for a request
// RD0   | reading line L0
// RD1   | reading line L1 (unaligned only)
// WR0   | writing line L0
// WR1   | writing line L1 (unaligned only)
// RESP  | one-cycle completion
module vect_lsu #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int AW     = 32
) (
    input logic      clk,
    input logic      rst,
    vect_lsu_if.slave bus
);
    localparam int DW = LANES * LANE_W;
    localparam int KW = $clog2(LANES);

    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

    state_t           state;
    logic             we_q;
    logic [KW-1:0]    k_q;
    logic [AW-1:0]    l0_q;
    logic [AW-1:0]    l1_q;
    logic [DW-1:0]    wdata_q;
    logic [LANES-1:0] mask_q;
    logic [DW-1:0]    buf0;
    logic [DW-1:0]    buf1;
    logic [DW-1:0]    rsp_rdata_q;
    logic [KW-1:0]    req_k;
    logic [AW-1:0]    req_l0;

    assign req_k  = bus.req_addr[KW-1:0];
    assign req_l0 = {bus.req_addr[AW-1:KW], {KW{1'b0}}};

    // Request lane i lands on absolute lane s = i+k; s >= LANES spills into line L1.
    function automatic logic [DW-1:0] gather(input logic [DW-1:0] line0, input logic [DW-1:0] line1,
                                             input logic [LANES-1:0] m, input logic [KW-1:0] k);
        logic [DW-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            s = i + int'(k);
            if (m[i]) begin
                if (s < LANES) r[i*LANE_W +: LANE_W] = line0[s*LANE_W +: LANE_W];
                else           r[i*LANE_W +: LANE_W] = line1[(s-LANES)*LANE_W +: LANE_W];
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] merge_lo(input logic [DW-1:0] line, input logic [DW-1:0] wd,
                                               input logic [LANES-1:0] m, input logic [KW-1:0] k);
        logic [DW-1:0] r;
        int s;
        r = line;
        for (int i = 0; i < LANES; i++) begin
            s = i + int'(k);
            if (m[i] && s < LANES) r[s*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] merge_hi(input logic [DW-1:0] line, input logic [DW-1:0] wd,
                                               input logic [LANES-1:0] m, input logic [KW-1:0] k);
        logic [DW-1:0] r;
        int s;
        r = line;
        for (int i = 0; i < LANES; i++) begin
            s = i + int'(k);
            if (m[i] && s >= LANES) r[(s-LANES)*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            k_q         <= '0;
            l0_q        <= '0;
            l1_q        <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            buf0        <= '0;
            buf1        <= '0;
            rsp_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        k_q     <= req_k;
                        l0_q    <= req_l0;
                        l1_q    <= req_l0 + AW'(LANES);
                        wdata_q <= bus.req_wdata;
                        mask_q  <= bus.req_mask;
                        // Aligned all-lane store needs no read: the data is the whole line.
                        if (bus.req_we && req_k == '0 && (&bus.req_mask)) begin
                            buf0  <= bus.req_wdata;
                            state <= WR0;
                        end else begin
                            state <= RD0;
                        end
                    end
                end
                RD0: begin
                    buf0 <= we_q ? merge_lo(bus.mem_rd, wdata_q, mask_q, k_q) : bus.mem_rd;
                    if (k_q != '0) begin
                        state <= RD1;
                    end else if (we_q) begin
                        state <= WR0;
                    end else begin
                        rsp_rdata_q <= gather(bus.mem_rd, buf1, mask_q, k_q);
                        state       <= RESP;
                    end
                end
                RD1: begin
                    buf1 <= we_q ? merge_hi(bus.mem_rd, wdata_q, mask_q, k_q) : bus.mem_rd;
                    if (we_q) begin
                        state <= WR0;
                    end else begin
                        rsp_rdata_q <= gather(buf0, bus.mem_rd, mask_q, k_q);
                        state       <= RESP;
                    end
                end
                WR0: begin
                    if (k_q != '0) begin
                        state <= WR1;
                    end else begin
                        rsp_rdata_q <= '0;
                        state       <= RESP;
                    end
                end
                WR1: begin
                    rsp_rdata_q <= '0;
                    state       <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_we    = (state == WR0) || (state == WR1);
    assign bus.mem_a     = (state == RD0 || state == WR0) ? l0_q :
                           (state == RD1 || state == WR1) ? l1_q : '0;
    assign bus.mem_wd    = (state == WR0) ? buf0 :
                           (state == WR1) ? buf1 : '0;
endmodule

// File: tb/tb_vect_lsu.sv
// Bench for vect_lsu: table of requests checked against a per-halfword memory model,
// with a response scoreboard and a hand-written mid-operation reset sequence.
module tb_vect_lsu;
    localparam int LANES  = 16;
    localparam int LANE_W = 16;
    localparam int AW     = 32;
    localparam int DW     = LANES * LANE_W;

    typedef struct {
        logic          we;
        logic [31:0]   addr;
        logic [DW-1:0] wdata;
        logic [15:0]   mask;
        int            lat;
        int            wes;
        logic [31:0]   a0;
        logic [31:0]   a1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vect_lsu_if #(.LANES(LANES), .LANE_W(LANE_W), .AW(AW)) bif();
    vect_lsu #(.LANES(LANES), .LANE_W(LANE_W), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bif));

    logic [DW-1:0] mem     [16];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] sb_exp;
    int total = 0;
    int bad   = 0;
    vec_t vt [22];

    assign bif.mem_rd = mem[bif.mem_a[7:4]];
    always @(posedge clk) if (bif.mem_we) mem[bif.mem_a[7:4]] <= bif.mem_wd;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bif.rsp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 want no response");
            end else begin
                sb_exp = sb.pop_front();
                chk("rsp_rdata", bif.rsp_rdata, sb_exp);
            end
        end
    end

    function automatic logic [DW-1:0] pat(input logic [7:0] s);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[16*i +: 16] = {s, 8'(i)};
        return r;
    endfunction

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [DW-1:0] wd,
                                input logic [15:0] mask, input int lat, input int wes,
                                input logic [31:0] a0, input logic [31:0] a1);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wd; v.mask = mask;
        v.lat = lat; v.wes = wes; v.a0 = a0; v.a1 = a1;
        return v;
    endfunction

    // Element-by-element model: request lane i lives at halfword addr+i.
    task automatic model(input vec_t v, output logic [DW-1:0] rd);
        logic [31:0] ab;
        rd = '0;
        for (int i = 0; i < LANES; i++) begin
            ab = v.addr + 32'(i);
            if (v.mask[i]) begin
                if (v.we) ref_mem[ab[7:4]][16*ab[3:0] +: 16] = v.wdata[16*i +: 16];
                else      rd[16*i +: 16] = ref_mem[ab[7:4]][16*ab[3:0] +: 16];
            end
        end
    endtask

    task automatic run_req(input vec_t v, input string name);
        logic [DW-1:0] exp_rd;
        logic [31:0]   a_seq [2];
        logic [31:0]   ab;
        int guard = 0;
        int n = 0;
        int wes = 0;
        int rdy0 = 0;
        bit got = 0;
        while (!bif.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({name, ".ready_wait"}, DW'(bif.req_ready), DW'(1));
        model(v, exp_rd);
        sb.push_back(exp_rd);
        bif.req_valid = 1'b1;
        bif.req_we    = v.we;
        bif.req_addr  = v.addr;
        bif.req_wdata = v.wdata;
        bif.req_mask  = v.mask;
        @(posedge clk);
        a_seq[0] = '0;
        a_seq[1] = '0;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bif.req_valid = 1'b0;
                bif.req_we    = 1'($urandom);
                bif.req_addr  = $urandom;
                bif.req_wdata = {8{$urandom}};
                bif.req_mask  = 16'($urandom);
            end
            if (n <= 2) a_seq[n-1] = bif.mem_a;
            if (bif.mem_we) wes++;
            if (!bif.req_ready) rdy0++;
            if (bif.rsp_valid) got = 1;
        end
        chk({name, ".latency"}, DW'(n), DW'(v.lat));
        chk({name, ".mem_we_cycles"}, DW'(wes), DW'(v.wes));
        chk({name, ".ready_low_cycles"}, DW'(rdy0), DW'(v.lat));
        chk({name, ".mem_a0"}, DW'(a_seq[0]), DW'(v.a0));
        if (v.lat >= 3) chk({name, ".mem_a1"}, DW'(a_seq[1]), DW'(v.a1));
        if (v.we) begin
            ab = v.addr + 32'd15;
            chk({name, ".line_lo"}, mem[v.addr[7:4]], ref_mem[v.addr[7:4]]);
            chk({name, ".line_hi"}, mem[ab[7:4]], ref_mem[ab[7:4]]);
        end
        @(negedge clk);
        chk({name, ".ready_after"}, DW'(bif.req_ready), DW'(1));
        chk({name, ".rsp_one_cycle"}, DW'(bif.rsp_valid), DW'(0));
        chk({name, ".rdata_hold"}, bif.rsp_rdata, exp_rd);
    endtask

    initial begin
        vec_t v;
        int we_seen;
        bif.req_valid = 1'b0;
        bif.req_we    = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.req_mask  = '0;

        vt[0]  = mk(1, 32'd32, pat(8'h11), 16'hFFFF, 2, 1, 32'd32, 0);
        vt[1]  = mk(1, 32'd48, pat(8'h22), 16'hFFFF, 2, 1, 32'd48, 0);
        vt[2]  = mk(0, 32'd48, '0, 16'hFFFF, 2, 0, 32'd48, 0);
        vt[3]  = mk(0, 32'd40, '0, 16'hFFFF, 3, 0, 32'd32, 32'd48);
        vt[4]  = mk(0, 32'd40, '0, 16'h0F0F, 3, 0, 32'd32, 32'd48);
        vt[5]  = mk(1, 32'd44, pat(8'h33), 16'hFFFF, 5, 2, 32'd32, 32'd48);
        vt[6]  = mk(0, 32'd32, '0, 16'hFFFF, 2, 0, 32'd32, 0);
        vt[7]  = mk(0, 32'd48, '0, 16'hFFFF, 2, 0, 32'd48, 0);
        vt[8]  = mk(1, 32'd32, pat(8'h44), 16'h00FF, 3, 1, 32'd32, 32'd32);
        vt[9]  = mk(0, 32'd32, '0, 16'hFFFF, 2, 0, 32'd32, 0);
        vt[10] = mk(1, 32'd64, pat(8'h55), 16'hFFFF, 2, 1, 32'd64, 0);
        vt[11] = mk(1, 32'd80, pat(8'h66), 16'hFFFF, 2, 1, 32'd80, 0);
        vt[12] = mk(1, 32'd70, pat(8'h77), 16'h0000, 5, 2, 32'd64, 32'd80);
        vt[13] = mk(0, 32'd64, '0, 16'hFFFF, 2, 0, 32'd64, 0);
        vt[14] = mk(0, 32'd72, '0, 16'hFFFF, 3, 0, 32'd64, 32'd80);
        vt[15] = mk(1, 32'hFFFFFFF0, pat(8'h88), 16'hFFFF, 2, 1, 32'hFFFFFFF0, 0);
        vt[16] = mk(1, 32'h00000000, pat(8'h99), 16'hFFFF, 2, 1, 32'h00000000, 0);
        vt[17] = mk(0, 32'hFFFFFFF8, '0, 16'hFFFF, 3, 0, 32'hFFFFFFF0, 32'h0);
        vt[18] = mk(1, 32'hFFFFFFFC, pat(8'hAA), 16'hA5C3, 5, 2, 32'hFFFFFFF0, 32'h0);
        vt[19] = mk(0, 32'hFFFFFFF4, '0, 16'hFFFF, 3, 0, 32'hFFFFFFF0, 32'h0);
        vt[20] = mk(1, 32'h00000000, pat(8'hBB), 16'h7FFF, 3, 1, 32'h0, 32'h0);
        vt[21] = mk(0, 32'h00000000, '0, 16'hFFFF, 2, 0, 32'h0, 0);

        #1 rst = 1'b0;
        #11;
        chk("reset.req_ready", DW'(bif.req_ready), DW'(1));
        chk("reset.rsp_valid", DW'(bif.rsp_valid), DW'(0));
        chk("reset.rsp_rdata", bif.rsp_rdata, '0);
        chk("reset.mem_we", DW'(bif.mem_we), DW'(0));
        chk("reset.mem_a", DW'(bif.mem_a), DW'(0));
        chk("reset.mem_wd", bif.mem_wd, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 22; i++) run_req(vt[i], $sformatf("v%0d", i));

        // Reset while the unaligned store is in RD1: nothing written, no response.
        v = mk(1, 32'd36, pat(8'hCC), 16'hFFFF, 5, 2, 32'd32, 32'd48);
        bif.req_valid = 1'b1;
        bif.req_we    = v.we;
        bif.req_addr  = v.addr;
        bif.req_wdata = v.wdata;
        bif.req_mask  = v.mask;
        we_seen = 0;
        @(posedge clk);
        @(negedge clk);
        bif.req_valid = 1'b0;
        if (bif.mem_we) we_seen++;
        @(negedge clk);
        if (bif.mem_we) we_seen++;
        chk("abort.in_rd1_mem_a", DW'(bif.mem_a), DW'(48));
        #1 rst = 1'b0;
        #1;
        chk("abort.req_ready", DW'(bif.req_ready), DW'(1));
        chk("abort.mem_we", DW'(bif.mem_we), DW'(0));
        chk("abort.rsp_valid", DW'(bif.rsp_valid), DW'(0));
        chk("abort.rsp_rdata", bif.rsp_rdata, '0);
        repeat (3) begin
            @(negedge clk);
            if (bif.mem_we) we_seen++;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bif.mem_we) we_seen++;
        end
        chk("abort.we_cycles", DW'(we_seen), DW'(0));
        chk("abort.line32", mem[2], ref_mem[2]);
        chk("abort.line48", mem[3], ref_mem[3]);

        run_req(mk(0, 32'd40, '0, 16'hFFFF, 3, 0, 32'd32, 32'd48), "post_abort_load");
        run_req(mk(1, 32'd36, pat(8'hDD), 16'hFFFF, 5, 2, 32'd32, 32'd48), "post_abort_store");

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", DW'(sb.size()), DW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vect_lsu.md
Name: vect_lsu

Overview:
- Vector load/store unit between the MEM-stage pipeline register and the vector memory (clk, we, a[31:0], wd[255:0], rd[255:0]; 16 lanes × 16 bit; halfword addressing; one line = 16 halfwords).
- Accepts one vector request at a time.
- Splits lane-unaligned accesses into two line accesses.
- Performs read-modify-write for partial-mask or unaligned stores.
- Returns one response per request.

Parameters:
- LANES, 16, elements per vector/line.
- LANE_W, 16, bits per element.
- AW, 32, address width (halfword address).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  AW  halfword address of lane 0.
- req_wdata  in  LANES*LANE_W  store data; lane i = bits [16i+15:16i].
- req_mask  in  LANES  lane enable.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  LANES*LANE_W  load result; 0 for stores.
- mem_we  out  1  vector memory write enable.
- mem_a  out  AW  line address to memory, always a multiple of 16.
- mem_wd  out  LANES*LANE_W  memory write data.
- mem_rd  in  LANES*LANE_W  memory read data, combinational on mem_a.

Behaviour:
- Reset (rst=0, takes effect immediately):
  - State IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, mem_we=0, mem_a=0, mem_wd=0.
  - Internal line buffers cleared.
- Address split: k = addr[3:0]; L0 = {addr[AW-1:4],4'b0}; L1 = L0+16, wrapping modulo 2^AW (0xFFFFFFF0 → 0x0).
  - Unaligned means k≠0.
  - Request lane i maps to absolute halfword addr+i.
- Handshake:
  - req_ready=1 only in IDLE.
  - Request accepted at the edge where req_valid&req_ready; all request fields latched at that edge.
  - req_* inputs are ignored outside IDLE.
- States: IDLE, RD0, RD1, WR0, WR1, RESP.
  - mem_we=1 only in WR0/WR1; it is decoded from state.
  - mem_a = L0 in RD0/WR0, L1 in RD1/WR1.
- Load path: IDLE → RD0 → (RD1 if k≠0) → RESP → IDLE.
  - mem_rd is captured at the end of each RD state.
  - Result lane i = line0 lane k+i for i<16-k, else line1 lane i-(16-k).
  - Lanes with mask=0 read as 0.
- Store path, full write (k=0 and mask=all ones): IDLE → WR0 → RESP. No read is performed.
- Store path, all other stores: IDLE → RD0 → (RD1 if k≠0) → WR0 → (WR1 if k≠0) → RESP.
  - Each target lane is replaced by req_wdata lane i only where mask[i]=1.
  - All other lanes keep the value read from memory.
- Mask=0 store: still executes the full RMW sequence; memory content is unchanged.
- Latency, accept edge to rsp_valid high:
  - 2 cycles: aligned load, full aligned store.
  - 3 cycles: unaligned load, partial aligned store.
  - 5 cycles: unaligned store.
- RESP lasts exactly 1 cycle.
  - rsp_rdata holds its value until the next RESP or reset.
  - req_ready returns to 1 in the cycle after RESP.
- Reset mid-operation: sequence aborted, mem_we drops immediately, no response issued. A write whose edge already occurred is not undone.

Test Plan:
1. Reset then aligned full store: addr=32, mask=FFFF, data D → exactly one cycle with mem_we=1, mem_a=32, mem_wd=D; rsp_valid 2 cycles after accept; req_ready=0 for 2 cycles.
2. Aligned load: addr=48 after storing D at 48 → one read at mem_a=48; rsp_rdata=D; 2-cycle latency.
3. Unaligned load: lines 32=A, 48=B, addr=40 → reads at 32 then 48; rsp_rdata lanes 0–7 = A lanes 8–15, lanes 8–15 = B lanes 0–7; 3-cycle latency.
4. Unaligned store: addr=44, data C, mask=FFFF, lines 32=A, 48=B → line 32 = {C lanes 0–3 in lanes 12–15, A lanes 0–11}; line 48 = {C lanes 4–15 in lanes 0–11, B lanes 12–15}; rsp_valid 5 cycles after accept.
5. Partial store: addr=32, mask=0x00FF, data C over A → line 32 lanes 0–7 = C, lanes 8–15 = A. Then addr=0xFFFFFFF8 unaligned load → second read at mem_a=0x00000000 (wrap).
6. Async reset asserted during RD1 of an unaligned store → mem_we never asserted, no rsp_valid, req_ready=1 immediately; the next request completes normally.
